// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - opcodes, register codes, station tags and instruction layout shared with dispatch
package dispatch_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  localparam logic [7:0] REG_R0 = 8'h10;
  localparam logic [7:0] REG_R1 = 8'h11;
  localparam logic [7:0] REG_R2 = 8'h12;
  localparam logic [7:0] REG_R3 = 8'h13;

  localparam logic [7:0] TAG_IDLE = 8'h00;
  localparam logic [7:0] TAG_A0   = 8'h20;
  localparam logic [7:0] TAG_A1   = 8'h21;
  localparam logic [7:0] TAG_A2   = 8'h22;
  localparam logic [7:0] TAG_M0   = 8'h30;
  localparam logic [7:0] TAG_M1   = 8'h31;

  // Field order matches instbus: [39:32] tag ... [7:0] destination
  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] opcode;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [7:0] dest;
  } inst_t;

  typedef struct packed {
    logic        rdy;
    logic [7:0]  tag;
    logic [31:0] value;
  } operand_t;

  typedef enum logic [1:0] {
    ADD_IDLE  = 2'd0,
    ADD_EXEC  = 2'd1,
    ADD_BCAST = 2'd2
  } add_state_e;

  function automatic logic is_reg(input logic [7:0] f);
    return f[7:2] == REG_R0[7:2];
  endfunction

  function automatic logic [31:0] reg_value(input logic [127:0] rf, input logic [1:0] r);
    logic [31:0] v;
    case (r)
      2'd0:    v = rf[31:0];
      2'd1:    v = rf[63:32];
      2'd2:    v = rf[95:64];
      default: v = rf[127:96];
    endcase
    return v;
  endfunction

  function automatic logic [2:0] a_target(input logic [7:0] tag);
    logic [2:0] t;
    case (tag)
      TAG_A0:  t = 3'b001;
      TAG_A1:  t = 3'b010;
      TAG_A2:  t = 3'b100;
      default: t = 3'b000;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] add_tag(input logic [1:0] idx);
    return TAG_A0 + {6'd0, idx};
  endfunction

endpackage

// File: rtl/add_rs_entry.sv
// rtl/add_rs_entry.sv - one add reservation station: capture, result-bus snoop, ready
module add_rs_entry (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         free,
  input  logic [7:0]   src1,
  input  logic [7:0]   src2,
  input  logic [127:0] rf_data,
  input  logic [39:0]  addbus,
  input  logic [39:0]  multbus,
  input  logic [39:0]  loadbus,
  output logic         valid,
  output logic         ready,
  output logic [31:0]  op1,
  output logic [31:0]  op2
);
  import dispatch_pkg::*;

  operand_t opa_q, opb_q;
  logic     valid_q;

  function automatic operand_t snoop(input operand_t o);
    operand_t r;
    r = o;
    if (!o.rdy && o.tag != TAG_IDLE) begin
      if (addbus[39:32] == o.tag) begin
        r.rdy = 1'b1;
        r.value = addbus[31:0];
      end else if (multbus[39:32] == o.tag) begin
        r.rdy = 1'b1;
        r.value = multbus[31:0];
      end else if (loadbus[39:32] == o.tag) begin
        r.rdy = 1'b1;
        r.value = loadbus[31:0];
      end
    end
    return r;
  endfunction

  // A producer broadcasting in the capture cycle is picked up immediately
  function automatic operand_t fetch(input logic [7:0] f);
    operand_t r;
    if (is_reg(f)) begin
      r = '{rdy: 1'b1, tag: f, value: reg_value(rf_data, f[1:0])};
    end else begin
      r = snoop('{rdy: 1'b0, tag: f, value: 32'd0});
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      opa_q   <= fetch(src1);
      opb_q   <= fetch(src2);
    end else begin
      if (free) valid_q <= 1'b0;
      opa_q <= snoop(opa_q);
      opb_q <= snoop(opb_q);
    end
  end

  assign valid = valid_q;
  assign ready = valid_q & opa_q.rdy & opb_q.rdy;
  assign op1   = opa_q.value;
  assign op2   = opb_q.value;

endmodule

// File: rtl/add_station.sv
// rtl/add_station.sv - three add reservation stations sharing one pipelined-latency adder
module add_station #(
  parameter int ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [39:0]  instbus1,
  input  logic         ib1_valid,
  input  logic [39:0]  instbus2,
  input  logic         ib2_valid,
  input  logic [127:0] rf_data,
  input  logic [39:0]  multbus,
  input  logic [39:0]  loadbus,
  output logic [39:0]  addbus,
  output logic [2:0]   busy,
  output logic         err
);
  import dispatch_pkg::*;

  localparam logic [2:0] LAT_M1 = 3'(ADD_LAT - 1);

  inst_t       i1, i2;
  logic [2:0]  tgt1, tgt2, hit1, hit2, free_ok, acc1, acc2;
  logic [2:0]  valid_v, ready_v, cand, inflight, free_vec;
  logic [31:0] op1_v [3];
  logic [31:0] op2_v [3];
  logic        err_hit, issue_en;
  logic [1:0]  sel, idx_d, cur_idx_q;
  logic [31:0] sum_new, sum_d, sum_q;
  logic [39:0] addbus_q;
  logic        err_q;
  logic [2:0]  cnt_q, cnt_d;
  add_state_e  state_q, state_d;
  logic        unused_dest;

  assign i1 = instbus1;
  assign i2 = instbus2;
  assign unused_dest = ^{i1.dest, i2.dest};

  assign tgt1    = ib1_valid ? a_target(i1.tag) : 3'b000;
  assign tgt2    = ib2_valid ? a_target(i2.tag) : 3'b000;
  assign hit1    = (i1.opcode == OP_ADD) ? tgt1 : 3'b000;
  assign hit2    = (i2.opcode == OP_ADD) ? tgt2 : 3'b000;
  assign free_ok = ~valid_v | free_vec;
  assign acc1    = hit1 & free_ok;
  assign acc2    = hit2 & ~tgt1 & free_ok;

  assign err_hit = (|tgt1 && i1.opcode != OP_ADD) || (|tgt2 && i2.opcode != OP_ADD)
                 || |(tgt1 & tgt2) || |(hit1 & ~free_ok) || |(hit2 & ~tgt1 & ~free_ok);

  for (genvar g = 0; g < 3; g++) begin : g_rs
    add_rs_entry u_rs (
      .clk     (clk),
      .rst     (rst),
      .load    (acc1[g] | acc2[g]),
      .free    (free_vec[g]),
      .src1    (acc1[g] ? i1.src1 : i2.src1),
      .src2    (acc1[g] ? i1.src2 : i2.src2),
      .rf_data (rf_data),
      .addbus  (addbus_q),
      .multbus (multbus),
      .loadbus (loadbus),
      .valid   (valid_v[g]),
      .ready   (ready_v[g]),
      .op1     (op1_v[g]),
      .op2     (op2_v[g])
    );
  end

  // The station owning the in-flight or broadcasting add must not be reissued
  assign inflight = (state_q != ADD_IDLE) ? (3'b001 << cur_idx_q) : 3'b000;
  assign cand     = valid_v & ready_v & ~inflight;

  always_comb begin
    sel = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (cand[i]) sel = 2'(i);
    end
  end

  assign sum_new = op1_v[sel] + op2_v[sel];
  assign idx_d   = issue_en ? sel : cur_idx_q;
  assign sum_d   = issue_en ? sum_new : sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ADD_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ADD_IDLE, ADD_BCAST: begin
        if (issue_en) begin
          state_d = (ADD_LAT == 1) ? ADD_BCAST : ADD_EXEC;
          cnt_d   = LAT_M1;
        end else begin
          state_d = ADD_IDLE;
        end
      end
      ADD_EXEC: begin
        if (cnt_q <= 3'd1) begin
          state_d = ADD_BCAST;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ADD_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    issue_en = (state_q != ADD_EXEC) && (|cand);
    free_vec = (state_q == ADD_BCAST) ? (3'b001 << cur_idx_q) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_idx_q <= 2'd0;
      sum_q     <= 32'd0;
      addbus_q  <= 40'd0;
      err_q     <= 1'b0;
    end else begin
      cur_idx_q <= idx_d;
      sum_q     <= sum_d;
      addbus_q  <= (state_d == ADD_BCAST) ? {add_tag(idx_d), sum_d} : 40'd0;
      err_q     <= err_q | err_hit;
    end
  end

  assign addbus = addbus_q;
  assign busy   = valid_v;
  assign err    = err_q;

endmodule

// File: tb/tb_add_station.sv
// tb/tb_add_station.sv - randomized and directed self-checking bench for add_station
module tb_add_station;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [39:0]  instbus1, instbus2, multbus, loadbus, addbus;
  logic         ib1_valid, ib2_valid, err;
  logic [127:0] rf_data;
  logic [2:0]   busy;

  always #5 clk = ~clk;

  add_station #(.ADD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .instbus1(instbus1), .ib1_valid(ib1_valid),
    .instbus2(instbus2), .ib2_valid(ib2_valid),
    .rf_data(rf_data), .multbus(multbus), .loadbus(loadbus),
    .addbus(addbus), .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  // Reference: stations as plain arrays, adder as a timeline of scheduled broadcasts
  logic        m_valid [3];
  logic        m_issued [3];
  logic        m_rdy [3][2];
  logic [7:0]  m_tag [3][2];
  logic [31:0] m_val [3][2];
  logic        pend_v;
  int          pend_cyc, pend_idx;
  logic [31:0] pend_val;
  int          cyc = 0;
  logic [39:0] m_addbus;
  logic [2:0]  m_busy;
  logic        m_err;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] resolve(input logic [7:0] f, input logic [39:0] ab);
    if (f >= 8'h10 && f <= 8'h13) return {1'b1, rf_data[32*(f-8'h10) +: 32]};
    if (f != 8'h00 && ab[39:32] == f) return {1'b1, ab[31:0]};
    if (f != 8'h00 && multbus[39:32] == f) return {1'b1, multbus[31:0]};
    if (f != 8'h00 && loadbus[39:32] == f) return {1'b1, loadbus[31:0]};
    return 33'd0;
  endfunction

  task automatic capture(input int t, input logic [39:0] inst, input logic [39:0] ab);
    logic [7:0]  f;
    logic [32:0] r;
    m_valid[t] = 1'b1;
    m_issued[t] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      f = (k == 0) ? inst[23:16] : inst[15:8];
      r = resolve(f, ab);
      m_tag[t][k] = f;
      m_rdy[t][k] = r[32];
      m_val[t][k] = r[31:0];
    end
  endtask

  task automatic model_step();
    logic [39:0] ab;
    logic [32:0] r;
    int f, pick, t1, t2;
    ab = m_addbus;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_issued[i] = 0;
        for (int k = 0; k < 2; k++) begin m_rdy[i][k] = 0; m_tag[i][k] = 0; m_val[i][k] = 0; end
      end
      pend_v = 0;
      m_err = 0;
    end else begin
      f = (pend_v && pend_cyc == cyc) ? pend_idx : -1;
      if (!pend_v || pend_cyc == cyc) begin
        pick = -1;
        for (int i = 0; i < 3; i++)
          if (pick < 0 && m_valid[i] && !m_issued[i] && m_rdy[i][0] && m_rdy[i][1]) pick = i;
        if (pick >= 0) begin
          pend_v = 1; pend_cyc = cyc + L; pend_idx = pick;
          pend_val = m_val[pick][0] + m_val[pick][1];
          m_issued[pick] = 1;
        end else begin
          pend_v = 0;
        end
      end
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 2; k++)
          if (!m_rdy[i][k]) begin
            r = resolve(m_tag[i][k], ab);
            if (r[32]) begin m_rdy[i][k] = 1; m_val[i][k] = r[31:0]; end
          end
      if (f >= 0) begin m_valid[f] = 0; m_issued[f] = 0; end
      t1 = (ib1_valid && instbus1[39:32] >= 8'h20 && instbus1[39:32] <= 8'h22) ? int'(instbus1[39:32]) - 32 : -1;
      t2 = (ib2_valid && instbus2[39:32] >= 8'h20 && instbus2[39:32] <= 8'h22) ? int'(instbus2[39:32]) - 32 : -1;
      if (t1 >= 0) begin
        if (instbus1[31:24] != 8'h03 || m_valid[t1]) m_err = 1;
        else capture(t1, instbus1, ab);
      end
      if (t2 >= 0) begin
        if (t2 == t1 || instbus2[31:24] != 8'h03 || m_valid[t2]) m_err = 1;
        else capture(t2, instbus2, ab);
      end
    end
    cyc++;
    m_addbus = (pend_v && pend_cyc == cyc) ? {8'h20 + 8'(pend_idx), pend_val} : 40'd0;
    m_busy = {m_valid[2], m_valid[1], m_valid[0]};
  endtask

  task automatic cycle();
    if (cmp_en) begin
      chk("addbus", addbus, m_addbus);
      chk("busy", {37'd0, busy}, {37'd0, m_busy});
      chk("err", {39'd0, err}, {39'd0, m_err});
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    rst = 0; ib1_valid = 0; ib2_valid = 0; multbus = '0; loadbus = '0;
    cmp_en = 1;
  endtask

  function automatic logic [39:0] mk(input logic [7:0] tag, op, s1, s2);
    return {tag, op, s1, s2, 8'h00};
  endfunction

  task automatic set_rf(input logic [31:0] r0, r1, r2, r3);
    rf_data = {r3, r2, r1, r0};
  endtask

  function automatic logic [7:0] rand_field();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 8'h10 + 8'($urandom_range(0, 3));
    if (r < 8) return 8'h20 + 8'($urandom_range(0, 2));
    return (r == 8) ? 8'h30 : 8'h40;
  endfunction

  function automatic logic [39:0] rand_inst();
    logic [7:0] tag, op;
    int r;
    r = $urandom_range(0, 9);
    tag = (r < 8) ? 8'h20 + 8'($urandom_range(0, 2)) : ((r == 8) ? 8'h30 : 8'h23);
    case ($urandom_range(0, 11))
      0: op = 8'h01;
      1: op = 8'h02;
      2: op = 8'h04;
      default: op = 8'h03;
    endcase
    return mk(tag, op, rand_field(), rand_field());
  endfunction

  initial begin
    rst = 1; ib1_valid = 0; ib2_valid = 0; instbus1 = '0; instbus2 = '0;
    multbus = '0; loadbus = '0; rf_data = '0;
    cycle();
    chk("reset_addbus", addbus, 40'd0);
    chk("reset_busy", {37'd0, busy}, 40'd0);

    // Single add, fixed latency
    set_rf(0, 5, 7, 0);
    instbus1 = mk(8'h20, 8'h03, 8'h11, 8'h12); ib1_valid = 1; cycle();
    chk("s1_c1_busy0", {39'd0, busy[0]}, 40'd1); cycle();
    chk("s1_c2_idle", addbus, 40'd0); cycle();
    chk("s1_c3_result", addbus, 40'h20_0000000C); cycle();
    chk("s1_c4_idle", addbus, 40'd0);
    chk("s1_c4_busy0", {39'd0, busy[0]}, 40'd0);

    // Pending operand woken by multbus
    rst = 1; cycle();
    set_rf(1, 0, 0, 0);
    instbus1 = mk(8'h21, 8'h03, 8'h30, 8'h10); ib1_valid = 1; cycle();
    for (int c = 1; c < 4; c++) begin chk("s2_wait", addbus, 40'd0); cycle(); end
    multbus = 40'h30_00000010; cycle();
    cycle();
    chk("s2_c6_idle", addbus, 40'd0); cycle();
    chk("s2_c7_result", addbus, 40'h21_00000011); cycle();

    // Two ready stations, lowest first
    rst = 1; cycle();
    set_rf(0, 5, 7, 9);
    instbus1 = mk(8'h20, 8'h03, 8'h11, 8'h12); ib1_valid = 1;
    instbus2 = mk(8'h21, 8'h03, 8'h13, 8'h10); ib2_valid = 1; cycle();
    cycle(); cycle();
    chk("s3_c3_a0", addbus, 40'h20_0000000C); cycle();
    chk("s3_c4_gap", addbus, 40'd0); cycle();
    chk("s3_c5_a1", addbus, 40'h21_00000009); cycle();

    // Wrap-around result chained via own broadcast bypass
    rst = 1; cycle();
    set_rf(32'hFFFF_FFFE, 1, 0, 0);
    instbus1 = mk(8'h20, 8'h03, 8'h10, 8'h11); ib1_valid = 1; cycle();
    cycle(); cycle();
    chk("s4_c3_a0", addbus, 40'h20_FFFFFFFF);
    set_rf(0, 0, 0, 2);
    instbus2 = mk(8'h22, 8'h03, 8'h20, 8'h13); ib2_valid = 1; cycle();
    cycle(); cycle();
    chk("s4_c6_a2", addbus, 40'h22_00000001); cycle();

    // Both buses target A1
    rst = 1; cycle();
    set_rf(0, 5, 6, 0);
    instbus1 = mk(8'h21, 8'h03, 8'h11, 8'h11); ib1_valid = 1;
    instbus2 = mk(8'h21, 8'h03, 8'h12, 8'h12); ib2_valid = 1; cycle();
    chk("s5_err", {39'd0, err}, 40'd1);
    chk("s5_busy", {37'd0, busy}, 40'd2); cycle(); cycle();
    chk("s5_result", addbus, 40'h21_0000000A); cycle(); cycle();
    chk("s5_err_sticky", {39'd0, err}, 40'd1);

    // Reset during EXEC flushes the add
    rst = 1; cycle();
    set_rf(0, 3, 4, 0);
    instbus1 = mk(8'h20, 8'h03, 8'h11, 8'h12); ib1_valid = 1;
    instbus2 = mk(8'h22, 8'h01, 8'h11, 8'h12); ib2_valid = 1; cycle();
    chk("s6_err_set", {39'd0, err}, 40'd1); cycle();
    rst = 1; instbus1 = mk(8'h21, 8'h03, 8'h11, 8'h12); ib1_valid = 1; cycle();
    chk("s6_flush_bus", addbus, 40'd0);
    chk("s6_flush_busy", {37'd0, busy}, 40'd0);
    chk("s6_flush_err", {39'd0, err}, 40'd0); cycle();
    chk("s6_no_late", addbus, 40'd0); cycle();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) rst = 1;
      if ($urandom_range(0, 4) == 0) rf_data = {$urandom, $urandom, $urandom, $urandom};
      ib1_valid = ($urandom_range(0, 9) < 4);
      ib2_valid = ($urandom_range(0, 9) < 4);
      instbus1 = rand_inst();
      instbus2 = rand_inst();
      if ($urandom_range(0, 6) == 0) multbus = {($urandom_range(0, 3) == 0) ? 8'h31 : 8'h30, 32'($urandom)};
      if ($urandom_range(0, 6) == 0) loadbus = {8'h40, 32'($urandom)};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
